// File: rtl/vtg_fbuf_scan.sv
// ---------------------------------------------------------------------------
// vtg_fbuf_scan
//   Multi-mode video timing generator with a framebuffer scan-address engine.
//   It runs free-running h/v counters for one of four standard modes and
//   derives the sync, active-video and blanking flags from them. In parallel
//   it walks the BRAM framebuffer incrementally, with no multiplier, using
//   power-of-two pixel replication.
//
// Ports
//   clk_i              pixel clock
//   rst_i              asynchronous active-high reset
//   mode_sel_i         requested mode, adopted only at the frame wrap
//   swap_req_i         level request to switch to next_base_i
//   next_base_i        base address of the next buffer
//   swap_ack_o         one-cycle pulse when next_base_i is adopted
//   hsync_o / vsync_o  syncs, polarity per mode (CONTROL_DELAY after counters)
//   vde_o              active video (CONTROL_DELAY after counters)
//   eof_o              vertical blanking (CONTROL_DELAY after counters)
//   frame_start_o      pulse with the first active pixel of a frame
//   fbuf_addr_o        framebuffer read address (one cycle after counters)
//   fbuf_addr_valid_o  fbuf_addr_o belongs to an active pixel
//   pixel_x_o/_y_o     unscaled pixel coordinates, 0 outside active video
//   active_mode_o      mode currently being generated
// ---------------------------------------------------------------------------
module vtg_fbuf_scan #(
    parameter int ADDR_W        = 19,
    parameter int SCALE_LOG2    = 0,
    parameter int CONTROL_DELAY = 2,
    parameter int DEFAULT_MODE  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_sel_i,
    input  logic              swap_req_i,
    input  logic [ADDR_W-1:0] next_base_i,
    output logic              swap_ack_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              vde_o,
    output logic              eof_o,
    output logic              frame_start_o,
    output logic [ADDR_W-1:0] fbuf_addr_o,
    output logic              fbuf_addr_valid_o,
    output logic [12:0]       pixel_x_o,
    output logic [12:0]       pixel_y_o,
    output logic [1:0]        active_mode_o
);

    typedef struct packed {
        logic [12:0] h_act;
        logic [12:0] hs_beg;
        logic [12:0] hs_end;
        logic [12:0] h_last;
        logic [12:0] v_act;
        logic [12:0] vs_beg;
        logic [12:0] vs_end;
        logic [12:0] v_last;
        logic        neg;
    } timing_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        eof;
        logic        fs;
        logic [12:0] px;
        logic [12:0] py;
    } ctrl_t;

    // Sync windows are stored as [begin, end) so the compare is a plain range test.
    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd0:    t = '{13'd640,  13'd656,  13'd752,  13'd799,
                           13'd480,  13'd490,  13'd492,  13'd524,  1'b1};
            2'd1:    t = '{13'd800,  13'd840,  13'd968,  13'd1055,
                           13'd600,  13'd601,  13'd605,  13'd627,  1'b0};
            2'd2:    t = '{13'd1280, 13'd1390, 13'd1430, 13'd1649,
                           13'd720,  13'd725,  13'd730,  13'd749,  1'b0};
            default: t = '{13'd1920, 13'd2008, 13'd2052, 13'd2199,
                           13'd1080, 13'd1084, 13'd1089, 13'd1124, 1'b0};
        endcase
        return t;
    endfunction

    localparam logic [1:0]  DEF_MODE = 2'(DEFAULT_MODE);
    localparam logic        DEF_NEG  = (DEFAULT_MODE == 0);
    localparam logic [12:0] ROW_MASK = 13'((1 << SCALE_LOG2) - 1);
    localparam ctrl_t       CTRL_RST = {DEF_NEG, DEF_NEG, 3'b000, 13'd0, 13'd0};

    logic [12:0]       h_q, h_d;
    logic [12:0]       v_q, v_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] cur_base_q, cur_base_d;
    logic              swap_ack_q, swap_ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;
    ctrl_t             ctrl_d;
    ctrl_t             pipe_q [CONTROL_DELAY];

    timing_t           tm;
    logic              h_end, v_end, frame_end;
    logic              in_h, in_v, active;
    logic              row_adv, swap_hit;
    logic [12:0]       v_inc;

    assign tm        = mode_timing(mode_q);
    assign h_end     = (h_q == tm.h_last);
    assign v_end     = (v_q == tm.v_last);
    assign frame_end = h_end & v_end;
    assign in_h      = (h_q < tm.h_act);
    assign in_v      = (v_q < tm.v_act);
    assign active    = in_h & in_v;
    assign v_inc     = v_q + 13'd1;

    // The row pointer advances after the last replicated copy of a source row.
    assign row_adv  = h_end & in_v & ((v_inc & ROW_MASK) == 13'd0);
    assign swap_hit = (h_q == 13'd0) & (v_q == tm.v_act) & swap_req_i;

    always_comb begin
        h_d    = h_q + 13'd1;
        v_d    = v_q;
        mode_d = mode_q;
        if (h_end) begin
            h_d = 13'd0;
            v_d = v_end ? 13'd0 : v_inc;
        end
        if (frame_end) begin
            mode_d = mode_sel_i;
        end
    end

    // cur_base only moves at h=0 of the first blanking line, so it is
    // settled well before the frame-end reload of row_base.
    always_comb begin
        row_base_d = row_base_q;
        if (frame_end) begin
            row_base_d = cur_base_q;
        end else if (row_adv) begin
            row_base_d = row_base_q + ADDR_W'(tm.h_act >> SCALE_LOG2);
        end
        cur_base_d   = swap_hit ? next_base_i : cur_base_q;
        swap_ack_d   = swap_hit;
        addr_d       = row_base_q + ADDR_W'(h_q >> SCALE_LOG2);
        addr_valid_d = active;
    end

    always_comb begin
        ctrl_d     = '0;
        ctrl_d.hs  = ((h_q >= tm.hs_beg) && (h_q < tm.hs_end)) ^ tm.neg;
        ctrl_d.vs  = ((v_q >= tm.vs_beg) && (v_q < tm.vs_end)) ^ tm.neg;
        ctrl_d.de  = active;
        ctrl_d.eof = ~in_v;
        ctrl_d.fs  = (h_q == 13'd0) && (v_q == 13'd0);
        ctrl_d.px  = active ? h_q : 13'd0;
        ctrl_d.py  = active ? v_q : 13'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q          <= '0;
            v_q          <= '0;
            mode_q       <= DEF_MODE;
            row_base_q   <= '0;
            cur_base_q   <= '0;
            swap_ack_q   <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            mode_q       <= mode_d;
            row_base_q   <= row_base_d;
            cur_base_q   <= cur_base_d;
            swap_ack_q   <= swap_ack_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    // Control delay line: the extra stages beyond the address register cover
    // the framebuffer read latency so pixels and controls line up downstream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < CONTROL_DELAY; i++) begin
                pipe_q[i] <= CTRL_RST;
            end
        end else begin
            pipe_q[0] <= ctrl_d;
            for (int i = 1; i < CONTROL_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign hsync_o           = pipe_q[CONTROL_DELAY-1].hs;
    assign vsync_o           = pipe_q[CONTROL_DELAY-1].vs;
    assign vde_o             = pipe_q[CONTROL_DELAY-1].de;
    assign eof_o             = pipe_q[CONTROL_DELAY-1].eof;
    assign frame_start_o     = pipe_q[CONTROL_DELAY-1].fs;
    assign pixel_x_o         = pipe_q[CONTROL_DELAY-1].px;
    assign pixel_y_o         = pipe_q[CONTROL_DELAY-1].py;
    assign swap_ack_o        = swap_ack_q;
    assign fbuf_addr_o       = addr_q;
    assign fbuf_addr_valid_o = addr_valid_q;
    assign active_mode_o     = mode_q;

endmodule

// File: tb/tb_vtg_fbuf_scan.sv
module tb_vtg_fbuf_scan;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        eof;
        logic        fs;
        logic [12:0] px;
        logic [12:0] py;
    } ctl_t;

    localparam int H_ACT [4] = '{640, 800, 1280, 1920};
    localparam int H_FP  [4] = '{16, 40, 110, 88};
    localparam int H_SW  [4] = '{96, 128, 40, 44};
    localparam int H_BP  [4] = '{48, 88, 220, 148};
    localparam int V_ACT [4] = '{480, 600, 720, 1080};
    localparam int V_FP  [4] = '{10, 1, 5, 4};
    localparam int V_SW  [4] = '{2, 4, 5, 5};
    localparam int V_BP  [4] = '{33, 23, 20, 36};
    localparam int DLY   [2] = '{2, 3};
    localparam int SCL   [2] = '{0, 1};
    localparam int DEFM  [2] = '{0, 2};

    logic clk, rst;
    logic [1:0]  mode_sel_a, mode_sel_b;
    logic        swap_req_a, swap_req_b;
    logic [18:0] next_base_a, next_base_b;

    logic        swap_ack_a, hsync_a, vsync_a, vde_a, eof_a, fs_a, valid_a;
    logic [18:0] addr_a;
    logic [12:0] px_a, py_a;
    logic [1:0]  mode_a;
    logic        swap_ack_b, hsync_b, vsync_b, vde_b, eof_b, fs_b, valid_b;
    logic [18:0] addr_b;
    logic [12:0] px_b, py_b;
    logic [1:0]  mode_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic cmp_en = 1'b0;

    vtg_fbuf_scan #(.ADDR_W(19), .SCALE_LOG2(0), .CONTROL_DELAY(2), .DEFAULT_MODE(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .mode_sel_i(mode_sel_a), .swap_req_i(swap_req_a),
        .next_base_i(next_base_a), .swap_ack_o(swap_ack_a), .hsync_o(hsync_a),
        .vsync_o(vsync_a), .vde_o(vde_a), .eof_o(eof_a), .frame_start_o(fs_a),
        .fbuf_addr_o(addr_a), .fbuf_addr_valid_o(valid_a), .pixel_x_o(px_a),
        .pixel_y_o(py_a), .active_mode_o(mode_a));

    vtg_fbuf_scan #(.ADDR_W(19), .SCALE_LOG2(1), .CONTROL_DELAY(3), .DEFAULT_MODE(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .mode_sel_i(mode_sel_b), .swap_req_i(swap_req_b),
        .next_base_i(next_base_b), .swap_ack_o(swap_ack_b), .hsync_o(hsync_b),
        .vsync_o(vsync_b), .vde_o(vde_b), .eof_o(eof_b), .frame_start_o(fs_b),
        .fbuf_addr_o(addr_b), .fbuf_addr_valid_o(valid_b), .pixel_x_o(px_b),
        .pixel_y_o(py_b), .active_mode_o(mode_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_h [2];
    int          m_v [2];
    int          m_mode [2];
    int unsigned m_base [2];
    int unsigned m_fbase [2];
    ctl_t        m_pipe [2][8];
    logic        e_ack [2];
    logic        e_valid [2];
    logic        e_addrchk [2];
    int unsigned e_addr [2];
    int          e_mode [2];

    task automatic model_reset(input int k);
        ctl_t r;
        logic neg;
        neg = (DEFM[k] == 0);
        r = {neg, neg, 3'b000, 13'd0, 13'd0};
        m_h[k] = 0; m_v[k] = 0; m_mode[k] = DEFM[k];
        m_base[k] = 0; m_fbase[k] = 0;
        for (int i = 0; i < 8; i++) m_pipe[k][i] = r;
        e_ack[k] = 1'b0; e_valid[k] = 1'b0; e_addrchk[k] = 1'b1;
        e_addr[k] = 0; e_mode[k] = DEFM[k];
    endtask

    task automatic model_step(input int k, input logic [1:0] sel, input logic sreq,
                              input logic [18:0] nb);
        int m, h, v, s, hact, vact, hsb, vsb, htot, vtot;
        logic neg;
        ctl_t c;
        m = m_mode[k]; h = m_h[k]; v = m_v[k]; s = SCL[k];
        hact = H_ACT[m]; vact = V_ACT[m];
        hsb  = hact + H_FP[m]; vsb = vact + V_FP[m];
        htot = hsb + H_SW[m] + H_BP[m]; vtot = vsb + V_SW[m] + V_BP[m];
        neg  = (m == 0);
        c.hs  = ((h >= hsb) && (h < hsb + H_SW[m])) ^ neg;
        c.vs  = ((v >= vsb) && (v < vsb + V_SW[m])) ^ neg;
        c.de  = (h < hact) && (v < vact);
        c.eof = (v >= vact);
        c.fs  = (h == 0) && (v == 0);
        c.px  = c.de ? 13'(h) : 13'd0;
        c.py  = c.de ? 13'(v) : 13'd0;
        e_valid[k]   = c.de;
        e_addrchk[k] = c.de;
        e_addr[k]    = (m_fbase[k] + (v >> s) * (hact >> s) + (h >> s)) & 32'h7FFFF;
        for (int i = DLY[k] - 1; i > 0; i--) m_pipe[k][i] = m_pipe[k][i-1];
        m_pipe[k][0] = c;
        e_ack[k] = (h == 0) && (v == vact) && sreq;
        if (e_ack[k]) m_base[k] = nb;
        h++;
        if (h == htot) begin
            h = 0;
            v++;
            if (v == vtot) begin
                v = 0;
                m_mode[k]  = sel;
                m_fbase[k] = m_base[k];
            end
        end
        m_h[k] = h; m_v[k] = v; e_mode[k] = m_mode[k];
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, mode_sel_a, swap_req_a, next_base_a);
            model_step(1, mode_sel_b, swap_req_b, next_base_b);
        end
    end

    task automatic check_inst(input int k, input ctl_t got, input logic ack, input logic val,
                              input logic [18:0] addr, input logic [1:0] mode);
        ctl_t ex;
        ex = m_pipe[k][DLY[k]-1];
        n_checks++;
        if (got !== ex || ack !== e_ack[k] || val !== e_valid[k] ||
            (e_addrchk[k] && addr !== 19'(e_addr[k])) || mode !== 2'(e_mode[k])) begin
            n_fail++;
            if (n_fail <= 10)
                $display("FAIL model_cmp inst%0d t=%0t: got ctl=%h ack=%b val=%b addr=%h mode=%0d, want ctl=%h ack=%b val=%b addr=%h mode=%0d",
                         k, $time, got, ack, val, addr, mode,
                         ex, e_ack[k], e_valid[k], 19'(e_addr[k]), e_mode[k]);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_inst(0, {hsync_a, vsync_a, vde_a, eof_a, fs_a, px_a, py_a},
                       swap_ack_a, valid_a, addr_a, mode_a);
            check_inst(1, {hsync_b, vsync_b, vde_b, eof_b, fs_b, px_b, py_b},
                       swap_ack_b, valid_b, addr_b, mode_b);
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic goto_edge(input int k);
        if (k > cyc) repeat (k - cyc) @(posedge clk);
        cyc = k;
        #1;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        mode_sel_a = 2'd0; swap_req_a = 1'b0; next_base_a = '0;
        mode_sel_b = 2'd2; swap_req_b = 1'b0; next_base_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr_a", int'(addr_a), 0);
        chk("rst_valid_a", int'(valid_a), 0);
        chk("rst_hsync_a", int'(hsync_a), 1);
        chk("rst_vsync_a", int'(vsync_a), 1);
        chk("rst_mode_a", int'(mode_a), 0);
        chk("rst_hsync_b", int'(hsync_b), 0);
        chk("rst_mode_b", int'(mode_b), 2);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        goto_edge(1);
        chk("first_valid_a", int'(valid_a), 1);
        chk("first_addr_a", int'(addr_a), 0);
        chk("first_valid_b", int'(valid_b), 1);
        goto_edge(2);
        chk("frame_start_a", int'(fs_a), 1);
        goto_edge(3);
        chk("frame_start_a_end", int'(fs_a), 0);
        chk("frame_start_b", int'(fs_b), 1);
        goto_edge(640);
        chk("addr_639_0", int'(addr_a), 639);
        goto_edge(641);
        chk("valid_hblank_a", int'(valid_a), 0);
        goto_edge(657);
        chk("hsync_pre", int'(hsync_a), 1);
        goto_edge(658);
        chk("hsync_first_low", int'(hsync_a), 0);
        goto_edge(753);
        chk("hsync_last_low", int'(hsync_a), 0);
        goto_edge(754);
        chk("hsync_release", int'(hsync_a), 1);
        goto_edge(801);
        chk("addr_0_1", int'(addr_a), 640);
        goto_edge(1280);
        chk("b_addr_1279_0", int'(addr_b), 639);
        goto_edge(1281);
        chk("b_valid_hblank", int'(valid_b), 0);
        goto_edge(1392);
        chk("b_hsync_pre", int'(hsync_b), 0);
        goto_edge(1393);
        chk("b_hsync_active_high", int'(hsync_b), 1);
        goto_edge(2930);
        chk("b_addr_1279_1", int'(addr_b), 639);

        // Mid-frame mode change and swap request at v=100.
        goto_edge(80000);
        @(negedge clk);
        mode_sel_a  = 2'd3;
        next_base_a = 19'h7FF00;
        swap_req_a  = 1'b1;
        goto_edge(200000);
        chk("mode_held_midframe", int'(mode_a), 0);
        while (!swap_ack_a && cyc < 390000) goto_edge(cyc + 1);
        chk("swap_ack_cycle", cyc, 384001);
        @(negedge clk);
        swap_req_a = 1'b0;
        goto_edge(cyc + 1);
        chk("swap_ack_single", int'(swap_ack_a), 0);
        goto_edge(419999);
        chk("mode_before_wrap", int'(mode_a), 0);
        goto_edge(420000);
        chk("mode_after_wrap", int'(mode_a), 3);
        goto_edge(420001);
        chk("new_frame_addr", int'(addr_a), 32'h7FF00);
        goto_edge(420002);
        chk("frame_period", int'(fs_a), 1);
        goto_edge(420257);
        chk("addr_wrap_256", int'(addr_a), 0);
        goto_edge(422201);
        chk("mode3_line_len", int'(addr_a), 32'h680);

        // Asynchronous reset at h=300, v=2.
        goto_edge(424700);
        rst = 1'b1;
        #1;
        chk("async_addr", int'(addr_a), 0);
        chk("async_vde", int'(vde_a), 0);
        chk("async_hsync", int'(hsync_a), 1);
        chk("async_mode", int'(mode_a), 0);
        chk("async_px", int'(px_a), 0);
        chk("async_mode_b", int'(mode_b), 2);
        @(negedge clk);
        mode_sel_a = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        goto_edge(1);
        chk("post_rst_addr", int'(addr_a), 0);
        chk("post_rst_valid", int'(valid_a), 1);
        goto_edge(801);
        chk("post_rst_base", int'(addr_a), 640);
        goto_edge(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
